// File: rtl/interrupt_sequencer_if.sv
// Signal bundle between the interrupt sequencer (master) and the control FSM / pins (slave).
// Handshake: int_req is held with int_type/vec_addr/b_flag stable until a one-cycle
// int_ack; the fields then stay frozen until a one-cycle vec_done releases them.
interface interrupt_sequencer_if;
    logic        irq_n;
    logic        nmi_n;
    logic        P_I;
    logic        brk_req;
    logic        instr_boundary;
    logic        int_ack;
    logic        vec_done;
    logic        int_req;
    logic [1:0]  int_type;
    logic [15:0] vec_addr;
    logic        b_flag;
    logic        busy;

    modport master (
        input  irq_n, nmi_n, P_I, brk_req, instr_boundary, int_ack, vec_done,
        output int_req, int_type, vec_addr, b_flag, busy
    );

    modport slave (
        output irq_n, nmi_n, P_I, brk_req, instr_boundary, int_ack, vec_done,
        input  int_req, int_type, vec_addr, b_flag, busy
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// Conditions IRQ/NMI pins, tracks reset and BRK, and presents one prioritised
// interrupt request with its vector to the control FSM at instruction boundaries.
module interrupt_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] NMI_VEC     = 16'hFFFA,
    parameter logic [15:0] RST_VEC     = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC     = 16'hFFFE
) (
    input  logic                  clk,
    input  logic                  rst,
    interrupt_sequencer_if.master bus,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] TYPE_NONE  = 2'b00;
    localparam logic [1:0] TYPE_IRQ   = 2'b01;
    localparam logic [1:0] TYPE_NMI   = 2'b10;
    localparam logic [1:0] TYPE_RESET = 2'b11;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] irq_sync_q;
    logic [SYNC_STAGES-1:0] nmi_sync_q;
    logic                   nmi_dly_q;
    logic                   irq_s;
    logic                   nmi_s;
    logic                   nmi_edge;
    logic                   irq_live;

    logic rst_pend_q, rst_pend_d;
    logic nmi_pend_q, nmi_pend_d;
    logic brk_pend_q, brk_pend_d;

    logic [1:0]  type_q, type_d;
    logic [15:0] vec_q, vec_d;
    logic        b_q, b_d;

    logic [1:0]  sel_type;
    logic [15:0] sel_vec;
    logic        sel_b;
    logic        any_src;
    logic        take_src;
    logic        capture;
    logic        ack_take;
    logic        done_take;

    // Pin synchronisers idle high so reset release never fakes an NMI edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_sync_q <= '1;
            nmi_sync_q <= '1;
            nmi_dly_q  <= 1'b1;
        end else begin
            irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], bus.irq_n};
            nmi_sync_q <= {nmi_sync_q[SYNC_STAGES-2:0], bus.nmi_n};
            nmi_dly_q  <= nmi_s;
        end
    end

    assign irq_s    = irq_sync_q[SYNC_STAGES-1];
    assign nmi_s    = nmi_sync_q[SYNC_STAGES-1];
    assign nmi_edge = nmi_dly_q & ~nmi_s;
    assign irq_live = ~irq_s & ~bus.P_I;

    assign any_src   = rst_pend_q | nmi_pend_q | brk_pend_q | bus.brk_req | irq_live;
    assign take_src  = (bus.instr_boundary | bus.brk_req) & any_src;
    assign capture   = (state_q == S_IDLE) & take_src;
    assign ack_take  = (state_q == S_REQ) & bus.int_ack;
    assign done_take = (state_q == S_SERVICE) & bus.vec_done;

    // Priority RESET > NMI > BRK > IRQ; BRK shares the IRQ vector and differs only in B.
    always_comb begin
        sel_type = TYPE_IRQ;
        sel_vec  = IRQ_VEC;
        sel_b    = 1'b0;
        if (rst_pend_q) begin
            sel_type = TYPE_RESET;
            sel_vec  = RST_VEC;
        end else if (nmi_pend_q) begin
            sel_type = TYPE_NMI;
            sel_vec  = NMI_VEC;
        end else if (brk_pend_q | bus.brk_req) begin
            sel_b = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (take_src)     state_d = S_REQ;
            S_REQ:     if (bus.int_ack)  state_d = S_SERVICE;
            S_SERVICE: if (bus.vec_done) state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.int_req = 1'b0;
        bus.busy    = 1'b0;
        case (state_q)
            S_REQ: begin
                bus.int_req = 1'b1;
                bus.busy    = 1'b1;
            end
            S_SERVICE: bus.busy = 1'b1;
            default: ;
        endcase
    end

    // A new source event in the same cycle as the acknowledge keeps its pend set.
    always_comb begin
        rst_pend_d = rst_pend_q & ~(ack_take & (type_q == TYPE_RESET));
        nmi_pend_d = nmi_edge | (nmi_pend_q & ~(ack_take & (type_q == TYPE_NMI)));
        brk_pend_d = bus.brk_req | (brk_pend_q & ~(ack_take & (type_q == TYPE_IRQ) & b_q));
    end

    always_comb begin
        type_d = type_q;
        vec_d  = vec_q;
        b_d    = b_q;
        if (capture) begin
            type_d = sel_type;
            vec_d  = sel_vec;
            b_d    = sel_b;
        end else if (done_take) begin
            type_d = TYPE_NONE;
            vec_d  = 16'h0000;
            b_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_pend_q <= 1'b1;
            nmi_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            type_q     <= TYPE_NONE;
            vec_q      <= 16'h0000;
            b_q        <= 1'b0;
        end else begin
            rst_pend_q <= rst_pend_d;
            nmi_pend_q <= nmi_pend_d;
            brk_pend_q <= brk_pend_d;
            type_q     <= type_d;
            vec_q      <= vec_d;
            b_q        <= b_d;
        end
    end

    assign bus.int_type = type_q;
    assign bus.vec_addr = vec_q;
    assign bus.b_flag   = b_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: vector table, directed corner
// sequences and randomized traffic against a request-level reference model.
module tb_interrupt_sequencer;
    localparam int S = 2;

    // {int_req, int_type, vec_addr, b_flag, busy}
    localparam logic [20:0] E_IDLE    = 21'h0;
    localparam logic [20:0] E_RST_REQ = {1'b1, 2'b11, 16'hFFFC, 1'b0, 1'b1};
    localparam logic [20:0] E_RST_SVC = {1'b0, 2'b11, 16'hFFFC, 1'b0, 1'b1};
    localparam logic [20:0] E_NMI_REQ = {1'b1, 2'b10, 16'hFFFA, 1'b0, 1'b1};
    localparam logic [20:0] E_NMI_SVC = {1'b0, 2'b10, 16'hFFFA, 1'b0, 1'b1};
    localparam logic [20:0] E_IRQ_REQ = {1'b1, 2'b01, 16'hFFFE, 1'b0, 1'b1};
    localparam logic [20:0] E_IRQ_SVC = {1'b0, 2'b01, 16'hFFFE, 1'b0, 1'b1};
    localparam logic [20:0] E_BRK_REQ = {1'b1, 2'b01, 16'hFFFE, 1'b1, 1'b1};

    typedef struct packed {
        logic        irq_n;
        logic        nmi_n;
        logic        p_i;
        logic        brk;
        logic        bnd;
        logic        ack;
        logic        done;
        logic [20:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       pin_irq, pin_nmi, pin_pi;
    logic       r_brk, r_bnd, r_ack, r_done;
    vec_t       tbl[17];

    // Reference model: one outstanding request record plus pending sources.
    bit         m_rst_pend, m_nmi_pend, m_brk_pend;
    bit         m_active, m_acked, m_b;
    bit [1:0]   m_type;
    bit [15:0]  m_vec;
    bit         irq_hist[$];
    bit         nmi_hist[$];

    interrupt_sequencer_if bus();

    interrupt_sequencer #(.SYNC_STAGES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] dut_vec();
        return {bus.int_req, bus.int_type, bus.vec_addr, bus.b_flag, bus.busy};
    endfunction

    function automatic logic [20:0] model_vec();
        return {m_active && !m_acked, m_type, m_vec, m_b, m_active};
    endfunction

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (dbg_state=%0d) at %0t", name, act, exp, dbg_state, $time);
        end
    endtask

    task automatic model_reset();
        m_rst_pend = 1'b1;
        m_nmi_pend = 1'b0;
        m_brk_pend = 1'b0;
        m_active   = 1'b0;
        m_acked    = 1'b0;
        m_b        = 1'b0;
        m_type     = 2'd0;
        m_vec      = 16'h0;
        irq_hist.delete();
        nmi_hist.delete();
        for (int i = 0; i <= S; i++) begin
            irq_hist.push_back(1'b1);
            nmi_hist.push_back(1'b1);
        end
    endtask

    // hist[0] is the newest pin sample; hist[S-1] is the synchronised value, hist[S] the one before it.
    task automatic model_step();
        bit irq_s, nmi_s, nmi_d, nmi_fall, irq_live;
        irq_s    = irq_hist[S-1];
        nmi_s    = nmi_hist[S-1];
        nmi_d    = nmi_hist[S];
        nmi_fall = nmi_d && !nmi_s;
        irq_live = !irq_s && !bus.P_I;
        if (!m_active) begin
            if ((bus.instr_boundary || bus.brk_req) &&
                (m_rst_pend || m_nmi_pend || m_brk_pend || bus.brk_req || irq_live)) begin
                m_active = 1'b1;
                m_acked  = 1'b0;
                m_b      = 1'b0;
                if (m_rst_pend) begin
                    m_type = 2'd3; m_vec = 16'hFFFC;
                end else if (m_nmi_pend) begin
                    m_type = 2'd2; m_vec = 16'hFFFA;
                end else begin
                    m_type = 2'd1; m_vec = 16'hFFFE;
                    m_b    = m_brk_pend || bus.brk_req;
                end
            end
        end else if (!m_acked) begin
            if (bus.int_ack) begin
                m_acked = 1'b1;
                if (m_type == 2'd3)      m_rst_pend = 1'b0;
                else if (m_type == 2'd2) m_nmi_pend = 1'b0;
                else if (m_b)            m_brk_pend = 1'b0;
            end
        end else if (bus.vec_done) begin
            m_active = 1'b0;
            m_acked  = 1'b0;
            m_type   = 2'd0;
            m_vec    = 16'h0;
            m_b      = 1'b0;
        end
        if (nmi_fall)    m_nmi_pend = 1'b1;
        if (bus.brk_req) m_brk_pend = 1'b1;
        irq_hist.push_front(bus.irq_n);
        void'(irq_hist.pop_back());
        nmi_hist.push_front(bus.nmi_n);
        void'(nmi_hist.pop_back());
    endtask

    task automatic drive(input logic brk, input logic bnd, input logic ack, input logic done);
        bus.irq_n          = pin_irq;
        bus.nmi_n          = pin_nmi;
        bus.P_I            = pin_pi;
        bus.brk_req        = brk;
        bus.instr_boundary = bnd;
        bus.int_ack        = ack;
        bus.vec_done       = done;
    endtask

    // Called at posedge+1; leaves time at the next posedge+1.
    task automatic step(input logic brk, input logic bnd, input logic ack, input logic done);
        drive(brk, bnd, ack, done);
        @(posedge clk);
        model_step();
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        pin_irq = 1'b1;
        pin_nmi = 1'b1;
        pin_pi  = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("async_reset", dut_vec(), E_IDLE);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        tbl = '{
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_RST_REQ},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_RST_REQ},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_RST_SVC},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_RST_SVC},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, E_RST_SVC},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_IDLE},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_IDLE},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_IDLE},
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE},
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_IDLE},
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_IDLE},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_IRQ_REQ},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IRQ_REQ},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IRQ_REQ},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_IRQ_SVC},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_IDLE},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_IDLE}
        };

        rst     = 1'b1;
        pin_irq = 1'b1;
        pin_nmi = 1'b1;
        pin_pi  = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", dut_vec(), E_IDLE);
        rst = 1'b0;

        // Power-on RESET request, protocol-error inputs, masked then taken IRQ.
        for (int i = 0; i < 17; i++) begin
            pin_irq = tbl[i].irq_n;
            pin_nmi = tbl[i].nmi_n;
            pin_pi  = tbl[i].p_i;
            step(tbl[i].brk, tbl[i].bnd, tbl[i].ack, tbl[i].done);
            check($sformatf("table_row_%0d", i), dut_vec(), tbl[i].exp);
        end

        // Held-low NMI yields exactly one request.
        pin_nmi = 1'b0;
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("nmi_once_req", dut_vec(), E_NMI_REQ);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("nmi_once_svc", dut_vec(), E_NMI_SVC);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("nmi_once_done", dut_vec(), E_IDLE);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("nmi_held_no_rereq", dut_vec(), E_IDLE);
        pin_nmi = 1'b1;
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);

        // NMI, BRK and IRQ together: NMI, then BRK, then IRQ.
        pin_irq = 1'b0;
        pin_pi  = 1'b0;
        pin_nmi = 1'b0;
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("prio_nmi_first", dut_vec(), E_NMI_REQ);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("prio_nmi_done", dut_vec(), E_IDLE);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("prio_brk_second", dut_vec(), E_BRK_REQ);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("prio_irq_third", dut_vec(), E_IRQ_REQ);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        pin_irq = 1'b1;
        pin_pi  = 1'b1;
        pin_nmi = 1'b1;
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);

        // New NMI edge lands on the acknowledge of the current NMI.
        pin_nmi = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("nmi_first_req", dut_vec(), E_NMI_REQ);
        pin_nmi = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("nmi_req_hold", dut_vec(), E_NMI_REQ);
        pin_nmi = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("nmi_edge_on_ack", dut_vec(), E_NMI_SVC);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("nmi_second_req", dut_vec(), E_NMI_REQ);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("nmi_none_after", dut_vec(), E_IDLE);

        // Reset during SERVICE with an NMI pending.
        pin_irq = 1'b0;
        pin_pi  = 1'b0;
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_rst_irq_req", dut_vec(), E_IRQ_REQ);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        pin_nmi = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        pin_nmi = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_svc", dut_vec(), E_IRQ_SVC);
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("rst_rerequest", dut_vec(), E_RST_REQ);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("nmi_discarded", dut_vec(), E_IDLE);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) pin_irq = ~pin_irq;
            if ($urandom_range(0, 5) == 0) pin_nmi = ~pin_nmi;
            if ($urandom_range(0, 3) == 0) pin_pi = 1'($urandom_range(0, 1));
            r_brk  = ($urandom_range(0, 19) == 0);
            r_bnd  = ($urandom_range(0, 2) == 0);
            r_ack  = (m_active && !m_acked) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            r_done = (m_active && m_acked) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            else step(r_brk, r_bnd, r_ack, r_done);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
